// File: rtl/alu8_sequencer.sv
// Command sequencer for the 8-bit ripple ALU: single-cycle ops plus a
// shift-add multiply that reuses the ALU adder for eight passes.
module alu8_sequencer #(
    parameter int WIDTH     = 8,
    parameter int MUL_ITERS = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [WIDTH-1:0]   cmd_a,
    input  logic [WIDTH-1:0]   cmd_b,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [3:0]         alu_operation,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_zero,
    input  logic               alu_carry,
    input  logic               alu_overflow,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_result,
    output logic               rsp_zero,
    output logic               rsp_carry,
    output logic               rsp_overflow,
    output logic               rsp_error
);

    localparam int CNT_W = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_ITERS - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL,
        DONE
    } state_t;

    state_t state;
    state_t state_n;

    logic [2:0]         op_q;
    logic [WIDTH-1:0]   m_q;
    logic [WIDTH-1:0]   q_q;
    logic [WIDTH-1:0]   p_hi;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         exec_enc;
    logic [2*WIDTH-1:0] prod_n;

    // One shift-add step: adder carry becomes the new product MSB.
    assign prod_n = {alu_carry, alu_result, q_q[WIDTH-1:1]};

    always_comb begin
        exec_enc = ALU_AND;
        unique case (op_q)
            OP_AND:  exec_enc = ALU_AND;
            OP_OR:   exec_enc = ALU_OR;
            OP_ADD:  exec_enc = ALU_ADD;
            OP_SUB:  exec_enc = ALU_SUB;
            OP_SLT:  exec_enc = ALU_SLT;
            OP_NOR:  exec_enc = ALU_NOR;
            OP_MUL:  exec_enc = ALU_ADD;
            OP_ILL:  exec_enc = ALU_AND;
            default: exec_enc = ALU_AND;
        endcase
    end

    always_comb begin
        state_n       = state;
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        alu_a         = '0;
        alu_b         = '0;
        alu_operation = ALU_AND;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_n = (cmd_op == OP_MUL) ? MUL : EXEC;
                end
            end
            EXEC: begin
                alu_a         = m_q;
                alu_b         = q_q;
                alu_operation = exec_enc;
                state_n       = DONE;
            end
            MUL: begin
                alu_a         = p_hi;
                alu_b         = q_q[0] ? m_q : '0;
                alu_operation = ALU_ADD;
                if (cnt == LAST) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            op_q         <= '0;
            m_q          <= '0;
            q_q          <= '0;
            p_hi         <= '0;
            cnt          <= '0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_error    <= 1'b0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q <= cmd_op;
                        m_q  <= cmd_a;
                        q_q  <= cmd_b;
                        p_hi <= '0;
                        cnt  <= '0;
                    end
                end
                EXEC: begin
                    if (op_q == OP_ILL) begin
                        rsp_result   <= '0;
                        rsp_zero     <= 1'b1;
                        rsp_carry    <= 1'b0;
                        rsp_overflow <= 1'b0;
                        rsp_error    <= 1'b1;
                    end else begin
                        rsp_result   <= {{WIDTH{1'b0}}, alu_result};
                        rsp_zero     <= alu_zero;
                        rsp_carry    <= alu_carry;
                        rsp_overflow <= alu_overflow;
                        rsp_error    <= 1'b0;
                    end
                end
                MUL: begin
                    {p_hi, q_q} <= prod_n;
                    cnt         <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        rsp_result   <= prod_n;
                        rsp_zero     <= (prod_n == '0);
                        rsp_carry    <= |prod_n[2*WIDTH-1:WIDTH];
                        rsp_overflow <= 1'b0;
                        rsp_error    <= 1'b0;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu8_sequencer.sv
// Scoreboard bench for alu8_sequencer with a behavioural ripple ALU
// attached and a plain-arithmetic reference model for responses.
module tb_alu8_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_operation;
    logic [7:0]  alu_result;
    logic        alu_zero;
    logic        alu_carry;
    logic        alu_overflow;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_carry;
    logic        rsp_overflow;
    logic        rsp_error;

    alu8_sequencer dut (
        .clock(clock),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_a(cmd_a),
        .cmd_b(cmd_b),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_operation(alu_operation),
        .alu_result(alu_result),
        .alu_zero(alu_zero),
        .alu_carry(alu_carry),
        .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_result(rsp_result),
        .rsp_zero(rsp_zero),
        .rsp_carry(rsp_carry),
        .rsp_overflow(rsp_overflow),
        .rsp_error(rsp_error)
    );

    always #5 clock = ~clock;

    // Ripple ALU: {Ainvert, Bnegate, op}; Bnegate also feeds carry-in.
    logic [7:0] aa;
    logic [7:0] bb;
    logic [8:0] s;
    always_comb begin
        aa = alu_operation[3] ? ~alu_a : alu_a;
        bb = alu_operation[2] ? ~alu_b : alu_b;
        s = {1'b0, aa} + {1'b0, bb} + {8'd0, alu_operation[2]};
        alu_carry = s[8];
        alu_overflow = (aa[7] == bb[7]) && (s[7] != aa[7]);
        case (alu_operation[1:0])
            2'b00:   alu_result = aa & bb;
            2'b01:   alu_result = aa | bb;
            2'b10:   alu_result = s[7:0];
            default: alu_result = {7'd0, s[7] ^ alu_overflow};
        endcase
        alu_zero = (alu_result == 8'd0);
    end

    typedef struct {
        logic [15:0] res;
        logic        z;
        logic        c;
        logic        v;
        logic        e;
        int          acc;
        int          lat;
        int          adds;
        logic [3:0]  enc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;

    function automatic exp_t ref_model(input logic [2:0] op,
                                       input logic [7:0] a,
                                       input logic [7:0] b);
        exp_t e;
        int ua = a;
        int ub = b;
        int sa = $signed(a);
        int sbv = $signed(b);
        int r = 0;
        int sum = 0;
        e.c = 0; e.v = 0; e.e = 0;
        e.acc = 0; e.lat = 1; e.adds = 0; e.enc = 4'b0000;
        case (op)
            3'd0, 3'd1, 3'd2: begin
                sum = sa + sbv;
                e.c = (ua + ub) > 255;
                e.v = (sum > 127) || (sum < -128);
                if (op == 3'd0) r = ua & ub;
                else if (op == 3'd1) r = ua | ub;
                else r = (ua + ub) % 256;
                if (op == 3'd1) e.enc = 4'b0001;
                if (op == 3'd2) begin e.enc = 4'b0010; e.adds = 1; end
            end
            3'd3, 3'd4: begin
                sum = sa - sbv;
                e.c = (ua >= ub);
                e.v = (sum > 127) || (sum < -128);
                r = (op == 3'd3) ? (ua - ub + 256) % 256 : int'(sa < sbv);
                e.enc = (op == 3'd3) ? 4'b0110 : 4'b0111;
            end
            3'd5: begin
                sum = -sa - sbv - 1;
                e.c = ((255 - ua) + (255 - ub) + 1) > 255;
                e.v = (sum > 127) || (sum < -128);
                r = 255 - (ua | ub);
                e.enc = 4'b1100;
            end
            3'd6: begin
                r = ua * ub;
                e.c = r > 255;
                e.lat = 8; e.adds = 8; e.enc = 4'b0010;
            end
            default: begin
                r = 0;
                e.e = 1;
            end
        endcase
        e.res = r[15:0];
        e.z = (r == 0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clock);
            #2;
            case (rdy_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'b0;
                default: rsp_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard on each completed response handshake.
    logic        seen = 1'b0;
    logic [19:0] snap = '0;
    int          addc = 0;
    logic [3:0]  last_op = 4'b0000;
    always @(negedge clock) begin
        if (reset) begin
            seen = 1'b0;
            addc = 0;
            last_op = 4'b0000;
        end else begin
            if (alu_operation == 4'b0010) addc++;
            if (alu_operation != 4'b0000) last_op = alu_operation;
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got %0h expected none", rsp_result);
                end else begin
                    if (!seen) begin
                        chk("latency", cyc - sb[0].acc, sb[0].lat);
                        chk("alu_enc", last_op, sb[0].enc);
                        chk("add_cycles", addc, sb[0].adds);
                        seen = 1'b1;
                    end else begin
                        chk("stable", {rsp_result, rsp_zero, rsp_carry,
                                       rsp_overflow, rsp_error}, snap);
                    end
                    snap = {rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_error};
                    if (rsp_ready) begin
                        chk("result", rsp_result, sb[0].res);
                        chk("zero", rsp_zero, sb[0].z);
                        chk("carry", rsp_carry, sb[0].c);
                        chk("overflow", rsp_overflow, sb[0].v);
                        chk("error", rsp_error, sb[0].e);
                        void'(sb.pop_front());
                        seen = 1'b0;
                        addc = 0;
                        last_op = 4'b0000;
                    end
                end
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accept edge.
    task automatic send(input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b);
        int n = 0;
        exp_t e;
        while (!cmd_ready && n < 100) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op = 3'($urandom);
            cmd_a = 8'($urandom);
            cmd_b = 8'($urandom);
            @(posedge clock);
            #1;
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got cmd_ready=0 expected 1");
            cmd_valid = 1'b0;
            return;
        end
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        @(posedge clock);
        #1;
        e = ref_model(op, a, b);
        e.acc = cyc;
        sb.push_back(e);
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom);
        cmd_a = 8'($urandom);
        cmd_b = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 3'd0;
        cmd_a = 8'd0;
        cmd_b = 8'd0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_flags", {rsp_zero, rsp_carry, rsp_overflow, rsp_error}, 0);
        chk("rst_alu_ab", {alu_a, alu_b}, 0);
        chk("rst_alu_op", alu_operation, 0);
        reset = 1'b0;

        send(3'd2, 8'h7F, 8'h01);
        drain();
        send(3'd3, 8'h05, 8'h05);
        send(3'd4, 8'hFF, 8'h01);
        drain();
        send(3'd6, 8'hFF, 8'hFF);
        send(3'd6, 8'h00, 8'h37);
        drain();

        rdy_mode = 1;
        @(posedge clock);
        #1;
        send(3'd0, 8'hF0, 8'h3C);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("bp_valid_seen", rsp_valid, 1);
        repeat (5) begin
            cmd_valid = 1'b1;
            cmd_op = 3'd1;
            cmd_a = 8'h11;
            cmd_b = 8'h22;
            @(posedge clock);
            #1;
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_result", rsp_result, 16'h0030);
        end
        cmd_valid = 1'b0;
        rdy_mode = 0;
        @(posedge clock);
        #1;
        chk("bp_valid_drop", rsp_valid, 0);
        drain();

        send(3'd6, 8'h12, 8'h34);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        sb.delete();
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_op", alu_operation, 0);
        reset = 1'b0;
        send(3'd5, 8'h0F, 8'hF0);
        drain();

        send(3'd7, 8'($urandom), 8'($urandom));
        send(3'd1, 8'hA0, 8'h05);
        drain();

        rdy_mode = 2;
        repeat (40) begin
            send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clock);
                    #1;
                end
            end
        end
        drain();
        rdy_mode = 0;
        repeat (2) @(posedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
